// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates one shared single-port memory between an
//               instruction-fetch requester and a data-stage requester.
//               One access is outstanding at a time. The data stage normally
//               wins, but fetch wins once it has lost STARVE_MAX times in a
//               row, and requesters alternate on back-to-back traffic. An
//               access that sees no mem_ack within ACK_TIMEOUT busy cycles is
//               aborted: err is set (sticky) and the owner receives 0xDEADBEEF.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   STARVE_MAX   consecutive fetch losses before fetch is forced to win
//   ACK_TIMEOUT  busy cycles without mem_ack before the access is aborted
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch read request (held until if_done)
//   if_done/if_rdata          fetch completion pulse and read data
//   dm_req/dm_addr/dm_wdata   data-stage request, address, store data
//   dm_we/dm_size             1=store/0=load, size (0 word,1 half,2 byte)
//   dm_done/dm_rdata          data completion pulse, load data (0 for stores)
//   mem_en/mem_addr/mem_wdata shared memory port: active, address, write data
//   mem_rnw/mem_size          1=read/0=write, access size
//   mem_rdata/mem_ack         memory read data, access complete
//   stall_if/stall_dm         req & ~done per requester (combinational)
//   err                       sticky timeout flag
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_MAX  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rnw,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_dm,
  output logic        err
);

  localparam int SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int ACW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [SCW-1:0] STARVE_LIM   = SCW'(STARVE_MAX);
  localparam logic [ACW-1:0] ACK_LAST     = ACW'(ACK_TIMEOUT - 1);
  localparam logic [31:0]    TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state;
  logic           owner_dm;     // current access belongs to the data stage
  logic           alt_valid;    // this IDLE cycle directly follows a done pulse
  logic           alt_was_dm;   // the done pulse just given went to the data stage
  logic [SCW-1:0] starve_cnt;
  logic [ACW-1:0] ack_cnt;

  logic fetch_first;
  logic grant_dm;
  logic grant_if;

  // Arbitration decision, only acted upon in IDLE. Right after a completion
  // the other requester gets priority; otherwise data wins unless fetch has
  // been starved long enough.
  always_comb begin
    fetch_first = alt_valid ? alt_was_dm : (starve_cnt >= STARVE_LIM);
    grant_dm    = dm_req & (~if_req | ~fetch_first);
    grant_if    = if_req & ~grant_dm;
  end

  assign stall_if = if_req & ~if_done;
  assign stall_dm = dm_req & ~dm_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_dm   <= 1'b0;
      alt_valid  <= 1'b0;
      alt_was_dm <= 1'b0;
      starve_cnt <= '0;
      ack_cnt    <= '0;
      err        <= 1'b0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rnw    <= 1'b0;
      mem_size   <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      unique case (state)
        IDLE: begin
          alt_valid <= 1'b0;
          ack_cnt   <= '0;
          // Port outputs are loaded from the requester at grant time and then
          // held, so later changes on the request inputs do not reach memory.
          if (grant_dm) begin
            state     <= DM_BUSY;
            owner_dm  <= 1'b1;
            mem_en    <= 1'b1;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_rnw   <= ~dm_we;
            mem_size  <= dm_size;
          end else if (grant_if) begin
            state     <= IF_BUSY;
            owner_dm  <= 1'b0;
            mem_en    <= 1'b1;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_rnw   <= 1'b1;
            mem_size  <= 2'd0;
          end
          // Count a fetch loss only when fetch was actually waiting.
          if (if_req && grant_dm) begin
            if (starve_cnt < STARVE_LIM) begin
              starve_cnt <= starve_cnt + SCW'(1);
            end
          end else begin
            starve_cnt <= '0;
          end
        end

        IF_BUSY, DM_BUSY: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_en  <= 1'b0;
            ack_cnt <= '0;
            if (owner_dm) begin
              dm_done  <= 1'b1;
              dm_rdata <= mem_rnw ? mem_rdata : 32'd0;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (ack_cnt == ACK_LAST) begin
            // Abort: release the port and complete the owner with a marker.
            state   <= DONE;
            mem_en  <= 1'b0;
            err     <= 1'b1;
            ack_cnt <= '0;
            if (owner_dm) begin
              dm_done  <= 1'b1;
              dm_rdata <= TIMEOUT_DATA;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= TIMEOUT_DATA;
            end
          end else begin
            ack_cnt <= ack_cnt + ACW'(1);
          end
        end

        DONE: begin
          state      <= IDLE;
          alt_valid  <= 1'b1;
          alt_was_dm <= owner_dm;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: a table of isolated
//               accesses, hand-written multi-cycle sequences (arbitration
//               order, timeout, reset mid-access, request dropped mid-access)
//               and a randomized run against a transaction-timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int STARVE_MAX  = 4;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done, dm_req, dm_we, dm_done;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [1:0]  dm_size, mem_size;
  logic        mem_en, mem_rnw, mem_ack, stall_if, stall_dm, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .dm_size(dm_size), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rnw(mem_rnw), .mem_size(mem_size), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall_if(stall_if), .stall_dm(stall_dm), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'd0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  typedef struct {
    logic        if_req;
    logic        dm_req;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        exp_rnw;
    logic [1:0]  exp_size;
    logic        exp_dm;
    logic [31:0] exp_rdata;
  } vec_t;

  // One isolated access from a quiet IDLE: grant latency, latched port
  // values (live inputs are scrambled while busy), single done pulse.
  task automatic run_vec(input vec_t v, input int idx);
    bit hold_ok;
    if_req = v.if_req; dm_req = v.dm_req; dm_we = v.dm_we; dm_size = v.dm_size;
    if_addr = v.addr; dm_addr = v.addr; dm_wdata = v.wdata; mem_ack = 1'b0;
    tick();
    chk($sformatf("v%0d_mem_en", idx), 32'(mem_en), 32'h1);
    chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
    chk($sformatf("v%0d_rnw", idx), 32'(mem_rnw), 32'(v.exp_rnw));
    chk($sformatf("v%0d_size", idx), 32'(mem_size), 32'(v.exp_size));
    if (!v.exp_rnw) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
    chk($sformatf("v%0d_stall", idx), 32'(v.exp_dm ? stall_dm : stall_if), 32'h1);
    if_addr = ~v.addr; dm_addr = ~v.addr; dm_wdata = ~v.wdata;
    hold_ok = 1'b1;
    for (int k = 1; k <= v.lat; k++) begin
      if (mem_en !== 1'b1 || mem_addr !== v.addr) hold_ok = 1'b0;
      if (k == v.lat) begin
        mem_ack = 1'b1; mem_rdata = v.rdata;
      end
      tick();
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    chk($sformatf("v%0d_hold", idx), 32'(hold_ok), 32'h1);
    chk($sformatf("v%0d_if_done", idx), 32'(if_done), 32'(!v.exp_dm));
    chk($sformatf("v%0d_dm_done", idx), 32'(dm_done), 32'(v.exp_dm));
    chk($sformatf("v%0d_rdata", idx), v.exp_dm ? dm_rdata : if_rdata, v.exp_rdata);
    chk($sformatf("v%0d_en_drop", idx), 32'(mem_en), 32'h0);
    chk($sformatf("v%0d_stall_done", idx), 32'(v.exp_dm ? stall_dm : stall_if), 32'h0);
    quiet();
    tick();
    chk($sformatf("v%0d_one_pulse", idx), 32'(if_done | dm_done), 32'h0);
    tick();
  endtask

  vec_t vecs[6];

  // Randomized-run model state
  int          g, len, lat, owner, starve, last_done, last_owner;
  bit          busy, m_err, prev_ifd, prev_dmd;
  logic [31:0] e_addr, e_wdata, e_rd, rd_raw;
  logic        e_rnw;
  logic [1:0]  e_size;

  initial begin
    //            if  dm  we  size  addr          wdata        lat rdata         rnw sz  dm  exp_rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0400, 32'h0,       1, 32'h2402_0005, 1'b1, 2'd0, 1'b0, 32'h2402_0005};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_2000, 32'h0,       3, 32'h1122_3344, 1'b1, 2'd0, 1'b1, 32'h1122_3344};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_1000, 32'hCAFE,    1, 32'h5555_5555, 1'b0, 2'd0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_2002, 32'h0,       2, 32'h0000_ABCD, 1'b1, 2'd1, 1'b1, 32'h0000_ABCD};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0000_2003, 32'h7F,      4, 32'h9999_9999, 1'b0, 2'd2, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0404, 32'h0,       5, 32'h8C22_0000, 1'b1, 2'd0, 1'b0, 32'h8C22_0000};

    // ---------------- reset state ----------------
    quiet();
    rst = 1'b1;
    tick(); tick();
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_done", 32'({if_done, dm_done}), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // ---------------- table of isolated accesses ----------------
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // ---------------- both request: data first, then fetch ----------------
    if_req = 1'b1; if_addr = 32'h500;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1000; dm_wdata = 32'hCAFE; dm_size = 2'd0;
    tick();
    chk("both_en", 32'(mem_en), 32'h1);
    chk("both_rnw", 32'(mem_rnw), 32'h0);
    chk("both_wdata", mem_wdata, 32'hCAFE);
    chk("both_addr", mem_addr, 32'h1000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("both_dm_done", 32'(dm_done), 32'h1);
    chk("both_if_wait", 32'(if_done), 32'h0);
    chk("both_stall_if", 32'(stall_if), 32'h1);
    dm_addr = 32'h1004; dm_we = 1'b0;
    tick();
    chk("both_arb_gap", 32'(mem_en), 32'h0);
    tick();
    chk("alt_fetch_en", 32'(mem_en), 32'h1);
    chk("alt_fetch_addr", mem_addr, 32'h500);
    chk("alt_fetch_rnw", 32'(mem_rnw), 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    tick();
    mem_ack = 1'b0;
    chk("alt_if_done", 32'(if_done), 32'h1);
    chk("alt_if_rdata", if_rdata, 32'h1234);
    if_req = 1'b0;
    tick(); tick();
    chk("alt_dm_addr", mem_addr, 32'h1004);
    mem_ack = 1'b1; mem_rdata = 32'h4321;
    tick();
    mem_ack = 1'b0;
    chk("alt_dm_rdata", dm_rdata, 32'h4321);
    quiet();
    tick(); tick();

    // ---------------- timeout ----------------
    begin
      int cnt;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
      tick();
      cnt = 0;
      for (int k = 0; k < 24; k++) begin
        if (mem_en !== 1'b1) break;
        cnt++;
        tick();
      end
      chk("to_busy_cycles", 32'(cnt), 32'(ACK_TIMEOUT));
      chk("to_dm_done", 32'(dm_done), 32'h1);
      chk("to_rdata", dm_rdata, 32'hDEAD_BEEF);
      chk("to_err", 32'(err), 32'h1);
      dm_req = 1'b0;
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("to_stray_ack", 32'(if_done | dm_done | mem_en), 32'h0);
      tick();
      chk("to_err_sticky", 32'(err), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("to_err_cleared", 32'(err), 32'h0);
      tick();
    end

    // ---------------- reset in the second busy cycle ----------------
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3100;
    tick(); tick();
    rst = 1'b1; dm_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_en", 32'(mem_en), 32'h0);
    chk("mid_rst_done", 32'(dm_done), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("mid_rst_late_ack", 32'(dm_done | mem_en), 32'h0);
    tick();
    chk("mid_rst_no_done", 32'(dm_done), 32'h0);

    // ---------------- request dropped while busy ----------------
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3200;
    tick();
    dm_req = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_ack = 1'b0;
    chk("drop_dm_done", 32'(dm_done), 32'h1);
    chk("drop_rdata", dm_rdata, 32'h77);
    quiet();
    tick();

    // ---------------- randomized run against timing model ----------------
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    busy = 0; m_err = 0; prev_ifd = 0; prev_dmd = 0;
    starve = 0; last_done = -10; last_owner = 0;
    g = 0; len = 0; lat = 0; owner = 0;
    for (int c = 0; c < 3000; c++) begin
      bit done_now, en, ifd, dmd;
      done_now = busy && (c == g + len + 1);
      en       = busy && (c > g) && (c <= g + len);
      ifd      = done_now && owner == 1;
      dmd      = done_now && owner == 2;
      if (done_now && lat == 0) m_err = 1;
      chk("r_mem_en", 32'(mem_en), 32'(en));
      chk("r_if_done", 32'(if_done), 32'(ifd));
      chk("r_dm_done", 32'(dm_done), 32'(dmd));
      chk("r_err", 32'(err), 32'(m_err));
      if (en) begin
        chk("r_addr", mem_addr, e_addr);
        chk("r_rnw", 32'(mem_rnw), 32'(e_rnw));
        chk("r_size", 32'(mem_size), 32'(e_size));
        if (!e_rnw) chk("r_wdata", mem_wdata, e_wdata);
      end
      if (ifd) chk("r_if_rdata", if_rdata, e_rd);
      if (dmd) chk("r_dm_rdata", dm_rdata, e_rd);
      if (done_now) begin
        busy = 0; last_done = c; last_owner = owner;
      end

      // requesters hold until their done has been seen, then re-decide
      if (!if_req || prev_ifd) if_req = ($urandom_range(0, 9) < 6);
      if (!dm_req || prev_dmd) dm_req = ($urandom_range(0, 9) < 6);
      prev_ifd = ifd; prev_dmd = dmd;
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      dm_we = 1'($urandom_range(0, 1)); dm_size = 2'($urandom_range(0, 2));

      // memory: ack only at the chosen latency while busy, noise otherwise
      mem_rdata = $urandom;
      if (busy) begin
        mem_ack = (lat != 0) && (c == g + lat);
        if (mem_ack) mem_rdata = rd_raw;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end

      // arbitration in an idle cycle
      if (!busy && !done_now) begin
        if (if_req || dm_req) begin
          int win;
          if (if_req && dm_req) begin
            if (c == last_done + 1) win = (last_owner == 2) ? 1 : 2;
            else                    win = (starve >= STARVE_MAX) ? 1 : 2;
          end else begin
            win = if_req ? 1 : 2;
          end
          if (if_req && win == 2) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
          else                    starve = 0;
          busy = 1; g = c; owner = win;
          lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
          len = (lat == 0) ? ACK_TIMEOUT : lat;
          if (win == 1) begin
            e_addr = if_addr; e_rnw = 1'b1; e_size = 2'd0; e_wdata = '0;
          end else begin
            e_addr = dm_addr; e_rnw = ~dm_we; e_size = dm_size; e_wdata = dm_wdata;
          end
          rd_raw = $urandom;
          e_rd = (lat == 0) ? 32'hDEAD_BEEF : ((win == 2 && !e_rnw) ? 32'h0 : rd_raw);
        end else begin
          starve = 0;
        end
      end

      #1;
      chk("r_stall_if", 32'(stall_if), 32'(if_req && !ifd));
      chk("r_stall_dm", 32'(stall_dm), 32'(dm_req && !dmd));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
